// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with a per-register scoreboard (busy bits).
//
// Two combinational read ports return register data together with a busy
// flag that says whether the addressed register still awaits a write from
// an issued producer. A single write port updates a register and retires
// its busy mark. alloc_en marks a register busy; flush clears every busy
// mark without touching register contents.
//
// Parameters:
//   XLEN     - data width of every register
//   NREG     - number of registers (power of two, >= 2)
//   AW       - address width, derived from NREG
//   ZERO_REG - 1: register 0 reads 0, ignores writes, is never busy
//   BYPASS   - 1: a same-cycle write is forwarded to matching reads
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   wr_en/addr/data      - write port (also retires busy[wr_addr])
//   alloc_en/addr        - mark a register busy
//   flush                - clear all busy marks
//   rdN_en/addr          - read port N request
//   rdN_data, rdN_busy   - read port N data and busy flag (combinational)
//   busy_vec             - registered busy bit per register
module reg_file_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_addr,
    input  logic            flush,
    input  logic            rd1_en,
    input  logic [AW-1:0]   rd1_addr,
    input  logic            rd2_en,
    input  logic [AW-1:0]   rd2_addr,
    output logic [XLEN-1:0] rd1_data,
    output logic [XLEN-1:0] rd2_data,
    output logic            rd1_busy,
    output logic            rd2_busy,
    output logic [NREG-1:0] busy_vec
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;

    logic            w_wr_ok;
    logic            w_alloc_ok;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_hit1;
    logic            w_hit2;

    // Writes and allocs aimed at a hardwired-zero register 0 are dropped.
    assign w_wr_ok    = wr_en && !(ZERO_REG && (wr_addr == '0));
    assign w_alloc_ok = alloc_en && !(ZERO_REG && (alloc_addr == '0));

    assign w_hit1 = BYPASS && w_wr_ok && (wr_addr == rd1_addr);
    assign w_hit2 = BYPASS && w_wr_ok && (wr_addr == rd2_addr);

    // Retire first, then set: an alloc to the register being written in the
    // same cycle names a new producer, so the busy mark must survive.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (wr_en)
                w_busy_nxt[wr_addr] = 1'b0;
            if (w_alloc_ok)
                w_busy_nxt[alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            for (int unsigned i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_wr_ok)
                r_regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd1_data = '0;
        rd1_busy = 1'b0;
        if (rd1_en && !(ZERO_REG && (rd1_addr == '0))) begin
            rd1_data = w_hit1 ? wr_data : r_regs[rd1_addr];
            rd1_busy = r_busy[rd1_addr] && !w_hit1;
        end
    end

    always_comb begin
        rd2_data = '0;
        rd2_busy = 1'b0;
        if (rd2_en && !(ZERO_REG && (rd2_addr == '0))) begin
            rd2_data = w_hit2 ? wr_data : r_regs[rd2_addr];
            rd2_busy = r_busy[rd2_addr] && !w_hit2;
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb.
// Two instances share all inputs: dut (BYPASS=1) and dut_nb (BYPASS=0).
// Inputs are driven 1 time unit after a rising edge; combinational outputs
// are sampled 1 unit later, registered outputs after the following edge.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst, wr_en, alloc_en, flush, rd1_en, rd2_en;
    logic [4:0]  wr_addr, alloc_addr, rd1_addr, rd2_addr;
    logic [31:0] wr_data;
    logic [31:0] rd1_data, rd2_data, nb_rd1_data, nb_rd2_data;
    logic        rd1_busy, rd2_busy, nb_rd1_busy, nb_rd2_busy;
    logic [31:0] busy_vec, nb_busy_vec;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(32), .NREG(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd2_en(rd2_en), .rd2_addr(rd2_addr),
        .rd1_data(rd1_data), .rd2_data(rd2_data), .rd1_busy(rd1_busy),
        .rd2_busy(rd2_busy), .busy_vec(busy_vec)
    );

    reg_file_sb #(.XLEN(32), .NREG(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd2_en(rd2_en), .rd2_addr(rd2_addr),
        .rd1_data(nb_rd1_data), .rd2_data(nb_rd2_data), .rd1_busy(nb_rd1_busy),
        .rd2_busy(nb_rd2_busy), .busy_vec(nb_busy_vec)
    );

    task automatic idle();
        rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0; alloc_en = 0; alloc_addr = 0;
        flush = 0; rd1_en = 0; rd1_addr = 0; rd2_en = 0; rd2_addr = 0;
    endtask

    // Advance one clock edge; inputs may change right after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1;
        tick();
        idle(); rd1_en = 1; rd1_addr = 5; rd2_en = 1; rd2_addr = 31;
        #1;
        checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL reset_busy_vec got=%h exp=%h", busy_vec, 32'h0); end
        checks++; if (rd1_data !== 32'h0) begin failures++; $display("FAIL reset_rd1_data got=%h exp=%h", rd1_data, 32'h0); end
        checks++; if (rd2_data !== 32'h0) begin failures++; $display("FAIL reset_rd2_data got=%h exp=%h", rd2_data, 32'h0); end
        checks++; if (rd1_busy !== 1'b0 || rd2_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", rd1_busy, rd2_busy); end
    endtask

    task automatic test_write_read();
        idle(); wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        tick();
        idle(); rd1_en = 1; rd1_addr = 5; rd2_en = 0; rd2_addr = 5;
        #1;
        checks++; if (rd1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd1 got=%h exp=%h", rd1_data, 32'hDEADBEEF); end
        checks++; if (rd2_data !== 32'h0) begin failures++; $display("FAIL rd2_disabled got=%h exp=%h", rd2_data, 32'h0); end
        rd2_en = 1;
        #1;
        checks++; if (rd2_data !== 32'hDEADBEEF) begin failures++; $display("FAIL same_addr_rd2 got=%h exp=%h", rd2_data, 32'hDEADBEEF); end
        checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL write_nonbusy got=%h exp=%h", busy_vec, 32'h0); end
    endtask

    task automatic test_zero_reg();
        idle(); wr_en = 1; wr_addr = 0; wr_data = 32'h12345678;
        alloc_en = 1; alloc_addr = 0; rd1_en = 1; rd1_addr = 0;
        #1;
        checks++; if (rd1_data !== 32'h0) begin failures++; $display("FAIL zero_bypass got=%h exp=%h", rd1_data, 32'h0); end
        tick();
        idle(); rd1_en = 1; rd1_addr = 0;
        #1;
        checks++; if (rd1_data !== 32'h0) begin failures++; $display("FAIL zero_rd got=%h exp=%h", rd1_data, 32'h0); end
        checks++; if (rd1_busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", rd1_busy); end
        checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL zero_busy_vec got=%h exp=%h", busy_vec, 32'h0); end
    endtask

    task automatic test_bypass();
        idle(); wr_en = 1; wr_addr = 7; wr_data = 32'h1;
        tick();
        idle(); wr_en = 1; wr_addr = 7; wr_data = 32'h2; rd1_en = 1; rd1_addr = 7;
        #1;
        checks++; if (rd1_data !== 32'h2) begin failures++; $display("FAIL bypass_on got=%h exp=%h", rd1_data, 32'h2); end
        checks++; if (nb_rd1_data !== 32'h1) begin failures++; $display("FAIL bypass_off got=%h exp=%h", nb_rd1_data, 32'h1); end
        tick();
        idle(); rd1_en = 1; rd1_addr = 7;
        #1;
        checks++; if (rd1_data !== 32'h2) begin failures++; $display("FAIL bypass_on_next got=%h exp=%h", rd1_data, 32'h2); end
        checks++; if (nb_rd1_data !== 32'h2) begin failures++; $display("FAIL bypass_off_next got=%h exp=%h", nb_rd1_data, 32'h2); end
    endtask

    task automatic test_busy();
        idle(); alloc_en = 1; alloc_addr = 3;
        tick();
        idle(); rd2_en = 1; rd2_addr = 3;
        #1;
        checks++; if (rd2_busy !== 1'b1) begin failures++; $display("FAIL alloc_rd2_busy got=%b exp=1", rd2_busy); end
        checks++; if (busy_vec !== 32'h8) begin failures++; $display("FAIL alloc_busy_vec got=%h exp=%h", busy_vec, 32'h8); end
        wr_en = 1; wr_addr = 3; wr_data = 32'hAA;
        #1;
        checks++; if (rd2_busy !== 1'b0) begin failures++; $display("FAIL hit_rd2_busy got=%b exp=0", rd2_busy); end
        checks++; if (rd2_data !== 32'hAA) begin failures++; $display("FAIL hit_rd2_data got=%h exp=%h", rd2_data, 32'hAA); end
        checks++; if (nb_rd2_busy !== 1'b1) begin failures++; $display("FAIL nb_rd2_busy got=%b exp=1", nb_rd2_busy); end
        checks++; if (nb_rd2_data !== 32'h0) begin failures++; $display("FAIL nb_rd2_data got=%h exp=%h", nb_rd2_data, 32'h0); end
        tick();
        idle();
        checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL retire_busy_vec got=%h exp=%h", busy_vec, 32'h0); end
    endtask

    task automatic test_alloc_write_flush();
        idle(); alloc_en = 1; alloc_addr = 4; wr_en = 1; wr_addr = 4; wr_data = 32'h44;
        tick();
        idle(); rd1_en = 1; rd1_addr = 4;
        #1;
        checks++; if (busy_vec !== 32'h10) begin failures++; $display("FAIL alloc_wins got=%h exp=%h", busy_vec, 32'h10); end
        checks++; if (rd1_data !== 32'h44 || rd1_busy !== 1'b1) begin failures++; $display("FAIL alloc_wins_rd got=%h/%b exp=%h/1", rd1_data, rd1_busy, 32'h44); end
        idle(); alloc_en = 1; alloc_addr = 9; flush = 1; wr_en = 1; wr_addr = 6; wr_data = 32'h66;
        tick();
        idle(); rd2_en = 1; rd2_addr = 6;
        #1;
        checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL flush_busy_vec got=%h exp=%h", busy_vec, 32'h0); end
        checks++; if (rd2_data !== 32'h66) begin failures++; $display("FAIL flush_write got=%h exp=%h", rd2_data, 32'h66); end
    endtask

    task automatic test_no_counting();
        idle(); alloc_en = 1; alloc_addr = 2;
        tick();
        tick();
        idle(); wr_en = 1; wr_addr = 2; wr_data = 32'h2;
        tick();
        idle();
        checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL double_alloc got=%h exp=%h", busy_vec, 32'h0); end
    endtask

    task automatic test_back_to_back();
        idle(); wr_en = 1; wr_addr = 1; wr_data = 32'h11;
        tick();
        wr_addr = 2; wr_data = 32'h22;
        tick();
        wr_addr = 3; wr_data = 32'h33; alloc_en = 1; alloc_addr = 10;
        tick();
        idle(); rd1_en = 1; rd1_addr = 2; rd2_en = 1; rd2_addr = 10;
        #1;
        checks++; if (busy_vec !== 32'h400) begin failures++; $display("FAIL b2b_busy_vec got=%h exp=%h", busy_vec, 32'h400); end
        checks++; if (rd1_data !== 32'h22 || rd2_busy !== 1'b1) begin failures++; $display("FAIL b2b_rd got=%h/%b exp=%h/1", rd1_data, rd2_busy, 32'h22); end
        idle(); rst = 1; wr_en = 1; wr_addr = 12; wr_data = 32'hFF; alloc_en = 1; alloc_addr = 13;
        tick();
        idle();
        checks++; if (busy_vec !== 32'h0 || nb_busy_vec !== 32'h0) begin failures++; $display("FAIL midrst_busy_vec got=%h/%h exp=0", busy_vec, nb_busy_vec); end
        for (int i = 1; i <= 13; i++) begin
            rd1_en = 1; rd1_addr = 5'(i); rd2_en = 1; rd2_addr = 5'(i);
            #1;
            checks++;
            if (rd1_data !== 32'h0 || nb_rd2_data !== 32'h0 || rd2_busy !== 1'b0) begin
                failures++;
                $display("FAIL midrst_reg%0d got=%h/%h/%b exp=0/0/0", i, rd1_data, nb_rd2_data, rd2_busy);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_busy();
        test_alloc_write_flush();
        test_no_counting();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of every register in bits.
REQ-002 Parameter NREG, default 32, number of registers; SHALL be a power of two ≥ 2.
REQ-003 Parameter AW, default $clog2(NREG), address width; derived only, never overridden.
REQ-004 Parameter ZERO_REG, default 1; when 1, register 0 reads 0, ignores writes and is never busy.
REQ-005 Parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to matching reads.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 wr_en  input  1  write strobe; also retires the pending (busy) mark of wr_addr.
REQ-009 wr_addr  input  AW  write address.
REQ-010 wr_data  input  XLEN  write data.
REQ-011 alloc_en  input  1  marks alloc_addr pending (a producer has been issued).
REQ-012 alloc_addr  input  AW  register to mark busy.
REQ-013 flush  input  1  clears all busy marks; register contents are unaffected.
REQ-014 rd1_en, rd2_en  input  1 each  read-port enables.
REQ-015 rd1_addr, rd2_addr  input  AW each  read addresses.
REQ-016 rd1_data, rd2_data  output  XLEN each  combinational read data.
REQ-017 rd1_busy, rd2_busy  output  1 each  combinational: the addressed register awaits a write.
REQ-018 busy_vec  output  NREG  registered busy bit per register (bit i = register i).

Function
REQ-019 Write: at a rising edge with wr_en=1, registers[wr_addr] SHALL take wr_data, except when ZERO_REG=1 and wr_addr=0.
REQ-020 "Write hit" on port n: BYPASS=1, wr_en=1, wr_addr=rdn_addr, and the write is not suppressed by REQ-019.
REQ-021 rdn_data: 0 when rdn_en=0; 0 when ZERO_REG=1 and rdn_addr=0; wr_data on a write hit; otherwise registers[rdn_addr].
REQ-022 With BYPASS=0, rdn_data SHALL return the pre-edge value during a same-cycle write; the new value appears on the next cycle.
REQ-023 Both read ports are independent and may address the same register with identical results.
REQ-024 Busy update at each rising edge, in priority order: rst, then flush, then alloc, then write retire.
REQ-025 flush=1: all busy bits cleared next cycle; a same-cycle alloc_en is ignored; the wr_en data write still occurs.
REQ-026 alloc_en=1 without flush: busy[alloc_addr] set; ignored when ZERO_REG=1 and alloc_addr=0.
REQ-027 wr_en=1: busy[wr_addr] cleared unless the same cycle sets it (alloc_addr=wr_addr, alloc wins: new producer pending).
REQ-028 alloc to an already-busy register keeps it busy (no counting); a write to a non-busy register is legal and leaves it clear.
REQ-029 rdn_busy = rdn_en AND busy[rdn_addr] AND NOT write hit; 0 for register 0 when ZERO_REG=1.
REQ-030 busy_vec bit 0 SHALL be constant 0 when ZERO_REG=1.
REQ-031 Out-of-range behaviour does not exist: AW exactly covers NREG, so every address is valid.

Reset
REQ-032 At a rising edge with rst=1, all registers SHALL become 0 and busy_vec SHALL become 0; all other inputs ignored that cycle.
REQ-033 After reset, every rdn_data = 0 and every rdn_busy = 0 until a write/alloc occurs.
REQ-034 Reset asserted mid-operation (pending allocs, same-cycle write) SHALL discard the write and all busy marks.

Verification
REQ-035 Reset, then wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; next cycle rd1_addr=5, rd1_en=1 -> rd1_data=0xDEADBEEF; rd2_en=0 -> rd2_data=0.
REQ-036 ZERO_REG=1: write 0x12345678 to reg 0, alloc reg 0 -> rd1_data=0, rd1_busy=0, busy_vec[0]=0.
REQ-037 BYPASS=1: reg 7 holds 0x1; same cycle wr 7 = 0x2, rd1_addr=7 -> rd1_data=0x2; with BYPASS=0 -> 0x1, then 0x2 next cycle.
REQ-038 alloc 3 -> next cycle rd2_addr=3 gives rd2_busy=1, busy_vec=0x8; wr 3 = 0xAA same cycle as read -> rd2_busy=0, rd2_data=0xAA (BYPASS=1); busy_vec=0 next cycle.
REQ-039 Simultaneous alloc 4 and wr 4 -> busy_vec[4]=1 next cycle, reg 4 updated; alloc 9 with flush=1 -> busy_vec=0 next cycle.
REQ-040 Write regs 1..3 and alloc 10, then rst=1 for one cycle -> all reads 0, busy_vec=0; a write in the reset cycle is not stored.
